// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller.
//   irq_state_e : controller FSM state (IDLE / REQ / SERVICE)
//   IRQ_CNT_W   : width of the optional per-source take counters
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

    localparam int IRQ_CNT_W = 16;

endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt source's input path: SYNC_STAGES-deep flop synchroniser
// followed by a rising-edge detector (registered previous value).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_irq      : raw asynchronous interrupt line
//   o_edge     : one-cycle pulse on a synchronised 0->1 transition
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_irq,
    output logic o_edge
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_irq};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    // Pulse is valid in the cycle the synchronised level first reads high,
    // so the owning pending bit sets on the next edge.
    assign o_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/irq_ctrl.sv
// Fixed-priority interrupt controller with per-source pending bits, a
// software-writable enable mask and a single in-service request (no nesting).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   irq_in[NUM_SRC]     : raw asynchronous interrupt lines (level-high)
//   src_data            : packed per-source data, source i at [i*DATA_W +: DATA_W]
//   mask_we, mask_wdata : mask write strobe / value (1 = enabled)
//   hold                : pipeline stall, delays the take pulse
//   rti, rsi            : service complete (with / without return) from decode
//   interrupt           : one-cycle take pulse to fetch
//   irq_id, irq_data    : source ID and data captured at take, stable through service
//   pending, mask, busy : status
//   irq_count           : take count of irq_id (only with IRQ_COUNT_EN)
// Build option: define IRQ_COUNT_EN to add saturating per-source take counters.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int ID_W        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        irq_in,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic                      mask_we,
    input  logic [NUM_SRC-1:0]        mask_wdata,
    input  logic                      hold,
    input  logic                      rti,
    input  logic                      rsi,
    output logic                      interrupt,
    output logic [ID_W-1:0]           irq_id,
    output logic [DATA_W-1:0]         irq_data,
    output logic [NUM_SRC-1:0]        pending,
    output logic [NUM_SRC-1:0]        mask,
    output logic                      busy
`ifdef IRQ_COUNT_EN
    ,
    output logic [IRQ_CNT_W-1:0]      irq_count
`endif
);

    irq_state_e          r_state, w_state_nxt;
    logic [NUM_SRC-1:0]  r_pending;
    logic [NUM_SRC-1:0]  r_mask;
    logic                r_interrupt;
    logic [ID_W-1:0]     r_id;
    logic [DATA_W-1:0]   r_data;

    logic [NUM_SRC-1:0]  w_edge;
    logic [NUM_SRC-1:0]  w_elig;
    logic [NUM_SRC-1:0]  w_win_oh;
    logic [ID_W-1:0]     w_win_id;
    logic [DATA_W-1:0]   w_win_data;
    logic                w_found;
    logic                w_capture;
    logic                w_take;
    logic [NUM_SRC-1:0]  w_clr;

    // ---------------- input path ----------------
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        irq_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync_edge (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_irq  (irq_in[g]),
            .o_edge (w_edge[g])
        );
    end

    // ---------------- arbitration ----------------
    assign w_elig = r_pending & r_mask;

    // Lowest eligible index wins; winner's data slice is muxed alongside.
    always_comb begin
        w_found    = 1'b0;
        w_win_oh   = '0;
        w_win_id   = '0;
        w_win_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_elig[i] && !w_found) begin
                w_found     = 1'b1;
                w_win_oh[i] = 1'b1;
                w_win_id    = ID_W'(i);
                w_win_data  = src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // ---------------- FSM ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_take      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_capture   = 1'b1;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (!hold) begin
                    w_take      = 1'b1;
                    w_state_nxt = SERVICE;
                end
            end
            SERVICE: begin
                // Anything eligible now is picked up by the next IDLE cycle.
                if (rti || rsi) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_clr = w_capture ? w_win_oh : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pending   <= '0;
            r_mask      <= '1;
            r_interrupt <= 1'b0;
            r_id        <= '0;
            r_data      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            // New edge beats a same-cycle take clear.
            r_pending   <= (r_pending & ~w_clr) | w_edge;
            r_interrupt <= w_take;
            if (mask_we) r_mask <= mask_wdata;
            if (w_capture) begin
                r_id   <= w_win_id;
                r_data <= w_win_data;
            end
        end
    end

`ifdef IRQ_COUNT_EN
    logic [NUM_SRC-1:0][IRQ_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (w_take && (r_id == ID_W'(i)) && (r_cnt[i] != '1))
                    r_cnt[i] <= r_cnt[i] + 1'b1;
            end
        end
    end

    assign irq_count = r_cnt[r_id];
`endif

    assign interrupt = r_interrupt;
    assign irq_id    = r_id;
    assign irq_data  = r_data;
    assign pending   = r_pending;
    assign mask      = r_mask;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl (default parameters).
module tb_irq_ctrl;

    localparam int NUM_SRC = 4;
    localparam int DATA_W  = 32;
    localparam int ID_W    = 2;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NUM_SRC-1:0]        irq_in;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic                      mask_we;
    logic [NUM_SRC-1:0]        mask_wdata;
    logic                      hold, rti, rsi;
    logic                      interrupt;
    logic [ID_W-1:0]           irq_id;
    logic [DATA_W-1:0]         irq_data;
    logic [NUM_SRC-1:0]        pending, mask;
    logic                      busy;
`ifdef IRQ_COUNT_EN
    logic [15:0]               irq_count;
`endif

    int vectors = 0;
    int errors  = 0;

    irq_ctrl #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .SYNC_STAGES(2), .ID_W(ID_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq_in     (irq_in),
        .src_data   (src_data),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .hold       (hold),
        .rti        (rti),
        .rsi        (rsi),
        .interrupt  (interrupt),
        .irq_id     (irq_id),
        .irq_data   (irq_data),
        .pending    (pending),
        .mask       (mask),
        .busy       (busy)
`ifdef IRQ_COUNT_EN
        ,
        .irq_count  (irq_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Drive irq_in for exactly one sampling edge.
    task automatic pulse(input logic [NUM_SRC-1:0] v);
        irq_in = v;
        tick();
        irq_in = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; irq_in = '0; mask_we = 0; mask_wdata = '0;
        hold = 0; rti = 0; rsi = 0;
        src_data = '0;
        src_data[0*DATA_W +: DATA_W] = 32'h1111_0000;
        src_data[1*DATA_W +: DATA_W] = 32'hCAFE_0001;
        src_data[2*DATA_W +: DATA_W] = 32'hDEAD_BEEF;
        src_data[3*DATA_W +: DATA_W] = 32'h3333_0003;
        ticks(3);
        vectors++; if (interrupt !== 1'b0) begin errors++; $display("FAIL reset.interrupt got=%0b exp=0", interrupt); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset.busy got=%0b exp=0", busy); end
        vectors++; if (pending !== 4'b0000) begin errors++; $display("FAIL reset.pending got=%b exp=0000", pending); end
        vectors++; if (mask !== 4'b1111) begin errors++; $display("FAIL reset.mask got=%b exp=1111", mask); end
        vectors++; if (irq_id !== 2'd0) begin errors++; $display("FAIL reset.irq_id got=%0d exp=0", irq_id); end
        vectors++; if (irq_data !== 32'h0) begin errors++; $display("FAIL reset.irq_data got=%h exp=0", irq_data); end
        rst_n = 1'b1;
        ticks(2);
        vectors++; if (busy !== 1'b0 || pending !== 4'b0000) begin errors++; $display("FAIL reset.idle busy=%0b pending=%b exp 0/0000", busy, pending); end
    endtask

    task automatic test_single();
        pulse(4'b0100);                 // sampled at edge 1
        ticks(2);                       // edge 3
        vectors++; if (pending !== 4'b0100 || busy !== 1'b0) begin errors++; $display("FAIL single.pend pending=%b busy=%0b exp 0100/0", pending, busy); end
        tick();                         // edge 4: REQ
        vectors++; if (busy !== 1'b1 || interrupt !== 1'b0 || pending !== 4'b0000) begin errors++; $display("FAIL single.req busy=%0b int=%0b pending=%b exp 1/0/0000", busy, interrupt, pending); end
        tick();                         // edge 5: take
        vectors++; if (interrupt !== 1'b1) begin errors++; $display("FAIL single.int got=%0b exp=1", interrupt); end
        vectors++; if (irq_id !== 2'd2 || irq_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single.id id=%0d data=%h exp 2/deadbeef", irq_id, irq_data); end
        tick();
        vectors++; if (interrupt !== 1'b0 || busy !== 1'b1 || pending !== 4'b0000) begin errors++; $display("FAIL single.svc int=%0b busy=%0b pending=%b exp 0/1/0000", interrupt, busy, pending); end
        rsi = 1; tick(); rsi = 0;
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL single.exit busy got=%0b exp=0", busy); end
    endtask

    task automatic test_simultaneous();
        pulse(4'b1010);
        ticks(2);
        vectors++; if (pending !== 4'b1010) begin errors++; $display("FAIL simul.pend got=%b exp=1010", pending); end
        tick();
        vectors++; if (irq_id !== 2'd1 || pending !== 4'b1000) begin errors++; $display("FAIL simul.req1 id=%0d pending=%b exp 1/1000", irq_id, pending); end
        tick();
        vectors++; if (interrupt !== 1'b1 || irq_id !== 2'd1 || irq_data !== 32'hCAFE_0001) begin errors++; $display("FAIL simul.take1 int=%0b id=%0d data=%h exp 1/1/cafe0001", interrupt, irq_id, irq_data); end
        tick();
        rti = 1; tick(); rti = 0;       // back to IDLE
        vectors++; if (busy !== 1'b0 || interrupt !== 1'b0) begin errors++; $display("FAIL simul.idle busy=%0b int=%0b exp 0/0", busy, interrupt); end
        tick();
        vectors++; if (busy !== 1'b1 || interrupt !== 1'b0 || irq_id !== 2'd3 || pending !== 4'b0000) begin errors++; $display("FAIL simul.req2 busy=%0b int=%0b id=%0d pending=%b exp 1/0/3/0000", busy, interrupt, irq_id, pending); end
        tick();                         // 3 cycles after rti
        vectors++; if (interrupt !== 1'b1 || irq_id !== 2'd3 || irq_data !== 32'h3333_0003) begin errors++; $display("FAIL simul.take2 int=%0b id=%0d data=%h exp 1/3/33330003", interrupt, irq_id, irq_data); end
        tick();
        rti = 1; tick(); rti = 0;
    endtask

    task automatic test_mask();
        mask_we = 1; mask_wdata = 4'b1110; tick(); mask_we = 0;
        vectors++; if (mask !== 4'b1110) begin errors++; $display("FAIL mask.write got=%b exp=1110", mask); end
        pulse(4'b0001);
        ticks(2);
        vectors++; if (pending !== 4'b0001) begin errors++; $display("FAIL mask.pend got=%b exp=0001", pending); end
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++; if (interrupt !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mask.blocked int=%0b busy=%0b exp 0/0", interrupt, busy); end
        end
        mask_we = 1; mask_wdata = 4'b1111; tick(); mask_we = 0;
        vectors++; if (mask !== 4'b1111 || busy !== 1'b0) begin errors++; $display("FAIL mask.unmask mask=%b busy=%0b exp 1111/0", mask, busy); end
        tick();
        vectors++; if (busy !== 1'b1 || irq_id !== 2'd0 || interrupt !== 1'b0) begin errors++; $display("FAIL mask.req busy=%0b id=%0d int=%0b exp 1/0/0", busy, irq_id, interrupt); end
        tick();
        vectors++; if (interrupt !== 1'b1 || irq_id !== 2'd0 || irq_data !== 32'h1111_0000) begin errors++; $display("FAIL mask.take int=%0b id=%0d data=%h exp 1/0/11110000", interrupt, irq_id, irq_data); end
        tick();
        rsi = 1; tick(); rsi = 0;
    endtask

    task automatic test_hold();
        hold = 1;
        pulse(4'b1000);
        ticks(3);                       // edge 4: REQ
        vectors++; if (busy !== 1'b1 || irq_id !== 2'd3) begin errors++; $display("FAIL hold.req busy=%0b id=%0d exp 1/3", busy, irq_id); end
        src_data[3*DATA_W +: DATA_W] = 32'h0BAD_F00D;   // captured value must not follow
        for (int k = 0; k < 5; k++) begin
            rti = (k == 1);             // ignored in REQ
            tick();
            vectors++; if (interrupt !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL hold.stall%0d int=%0b busy=%0b exp 0/1", k, interrupt, busy); end
        end
        rti = 0; hold = 0;
        tick();
        vectors++; if (interrupt !== 1'b1 || irq_id !== 2'd3 || irq_data !== 32'h3333_0003) begin errors++; $display("FAIL hold.take int=%0b id=%0d data=%h exp 1/3/33330003", interrupt, irq_id, irq_data); end
        src_data[3*DATA_W +: DATA_W] = 32'h3333_0003;
        tick();
        rsi = 1; tick(); rsi = 0;
    endtask

    task automatic test_service_events();
        pulse(4'b0100);
        ticks(4);
        vectors++; if (interrupt !== 1'b1 || irq_id !== 2'd2) begin errors++; $display("FAIL svc.take1 int=%0b id=%0d exp 1/2", interrupt, irq_id); end
        pulse(4'b0100);                 // re-edge while in service
        ticks(2);
        vectors++; if (pending !== 4'b0100 || busy !== 1'b1) begin errors++; $display("FAIL svc.pend pending=%b busy=%0b exp 0100/1", pending, busy); end
        for (int k = 0; k < 2; k++) begin
            tick();
            vectors++; if (interrupt !== 1'b0) begin errors++; $display("FAIL svc.nopreempt int=%0b exp 0", interrupt); end
        end
        rsi = 1; tick(); rsi = 0;
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL svc.exit busy=%0b exp 0", busy); end
        tick();
        vectors++; if (busy !== 1'b1 || pending !== 4'b0000 || irq_id !== 2'd2) begin errors++; $display("FAIL svc.req2 busy=%0b pending=%b id=%0d exp 1/0000/2", busy, pending, irq_id); end
        tick();
        vectors++; if (interrupt !== 1'b1 || irq_id !== 2'd2) begin errors++; $display("FAIL svc.take2 int=%0b id=%0d exp 1/2", interrupt, irq_id); end
        tick();
        rsi = 1; tick(); rsi = 0;
    endtask

    task automatic test_reset_mid();
        pulse(4'b0010);
        ticks(4);
        vectors++; if (interrupt !== 1'b1 || irq_id !== 2'd1) begin errors++; $display("FAIL rstmid.take int=%0b id=%0d exp 1/1", interrupt, irq_id); end
        mask_we = 1; mask_wdata = 4'b0011; tick(); mask_we = 0;
        pulse(4'b0100);
        ticks(2);
        vectors++; if (pending !== 4'b0100 || mask !== 4'b0011 || busy !== 1'b1) begin errors++; $display("FAIL rstmid.pre pending=%b mask=%b busy=%0b exp 0100/0011/1", pending, mask, busy); end
        #2 rst_n = 1'b0;                // between clock edges
        #1;
        vectors++; if (busy !== 1'b0 || pending !== 4'b0000 || mask !== 4'b1111) begin errors++; $display("FAIL rstmid.async busy=%0b pending=%b mask=%b exp 0/0000/1111", busy, pending, mask); end
        vectors++; if (interrupt !== 1'b0 || irq_id !== 2'd0 || irq_data !== 32'h0) begin errors++; $display("FAIL rstmid.outs int=%0b id=%0d data=%h exp 0/0/0", interrupt, irq_id, irq_data); end
        ticks(2);
        rst_n = 1'b1;
        ticks(2);
    endtask

`ifdef IRQ_COUNT_EN
    task automatic test_count();
        vectors++; if (irq_count !== 16'd0) begin errors++; $display("FAIL count.reset got=%0d exp=0", irq_count); end
        for (int k = 0; k < 3; k++) begin
            pulse(4'b0010);
            ticks(4);
            rti = 1; tick(); rti = 0;
        end
        vectors++; if (irq_id !== 2'd1 || irq_count !== 16'd3) begin errors++; $display("FAIL count.three id=%0d count=%0d exp 1/3", irq_id, irq_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_mask();
        test_hold();
        test_service_events();
        test_reset_mid();
`ifdef IRQ_COUNT_EN
        test_count();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
Parametrised interrupt controller that replaces the two-input, single-latch interrupt scheme at the processor top level. It takes NUM_SRC asynchronous interrupt lines and synchronises and edge-detects each one. Pending requests are held per source and arbitrated by fixed priority under a software-writable mask. For each taken request it delivers a one-cycle `interrupt` pulse to fetch, plus the source ID and the captured source data for RDI. Sits beside fetch/decode; decode supplies `rti`/`rsi`, and the memory stage reads `irq_data`.

Parameters:
- NUM_SRC, 4, number of interrupt sources; index 0 has the highest priority.
- DATA_W, 32, width of each source's data word.
- SYNC_STAGES, 2, flip-flop synchroniser depth per source; minimum 2.
- ID_W, $clog2(NUM_SRC) (minimum 1), width of the source ID.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- irq_in  in  NUM_SRC  raw asynchronous interrupt lines, level-high
- src_data  in  NUM_SRC*DATA_W  per-source data, packed; source i occupies [i*DATA_W +: DATA_W]
- mask_we  in  1  mask write strobe
- mask_wdata  in  NUM_SRC  new mask value; 1 = enabled
- hold  in  1  pipeline stall; delays issue of `interrupt`
- rti  in  1  return from interrupt (decode)
- rsi  in  1  service-complete without return (decode)
- interrupt  out  1  one-cycle take pulse to fetch/flush
- irq_id  out  ID_W  ID of the source in service
- irq_data  out  DATA_W  src_data captured when the request was taken
- pending  out  NUM_SRC  pending bit vector
- mask  out  NUM_SRC  current mask
- busy  out  1  high in REQ or SERVICE

Behaviour:
- Reset: all synchroniser flops, edge registers and `pending` = 0; `mask` = all 1s; state = IDLE; `interrupt` = 0; `irq_id` = 0; `irq_data` = 0; `busy` = 0.
- Input path: each `irq_in` bit passes through SYNC_STAGES flops, then a registered rising-edge detector. Edge-to-pending latency is SYNC_STAGES+1 cycles.
- Pending set/clear: a detected edge sets `pending[i]`. The bit clears only in the cycle its request is taken. If set and clear hit the same bit in the same cycle, set wins and the bit stays 1.
- Masking: masked sources still latch into `pending` but are not arbitrated. `mask_we` updates the mask on the next edge, and the new mask takes effect for arbitration in the following cycle.
- Arbitration: eligible = pending & mask; the winner is the lowest eligible index. Arbitration is combinational and registered at entry to REQ.
- FSM states:
  - IDLE: if eligible != 0, capture the winner into `irq_id` and its `src_data` slice into `irq_data`, clear `pending[winner]`, go to REQ.
  - REQ: if hold=0, assert `interrupt` for exactly 1 cycle and go to SERVICE. If hold=1, stay in REQ with `interrupt`=0.
  - SERVICE: `interrupt`=0. On `rti` or `rsi`, go to IDLE; if eligible != 0 in that same cycle, arbitration happens in the next IDLE cycle.
- `irq_id` and `irq_data` stay stable from REQ through the end of SERVICE.
- Edges arriving during REQ or SERVICE are recorded in `pending` and never preempt the request in service; there is no nesting.
- `rti`/`rsi` in IDLE or REQ are ignored.
- Minimum gap between consecutive `interrupt` pulses: 3 cycles (SERVICE exit → IDLE → REQ → pulse).
- Asserting rst_n low mid-service returns everything to reset values immediately; the in-service request is lost.

Optional Feature:
IRQ_COUNT_EN:
- When defined: adds output `irq_count` (16 bits). There is one saturating 16-bit counter per source, incremented on each `interrupt` pulse for that source and saturating at 16'hFFFF. `irq_count` shows the counter of `irq_id`. All counters reset to 0.
- When undefined: no counters are built and the port does not exist.

Decomposition:
- Shared package `irq_pkg`: the state enum typedef (IDLE/REQ/SERVICE) and the count-width constant (16).
- One natural sub-module: `irq_sync_edge` (one source's synchroniser plus edge detector, parametrised by SYNC_STAGES), instantiated NUM_SRC times in a generate loop.

Test Plan:
- Single source: pulse `irq_in`=4'b0100 with src_data[2]=32'hDEAD_BEEF → `interrupt` 1 cycle at cycle SYNC_STAGES+3 after the pulse; irq_id=2, irq_data=32'hDEAD_BEEF; `pending`=0 afterwards.
- Simultaneous: irq_in=4'b1010 in the same cycle → first take id=1. Assert rti → second pulse with id=3, 3 cycles after rti.
- Mask: write mask=4'b1110, then pulse source 0 → pending=4'b0001 and no interrupt. Write mask=4'b1111 → pulse with id=0 two cycles later.
- Hold: hold=1 for 5 cycles while in REQ → no pulse during those cycles; the pulse comes 1 cycle after hold drops, with id/data unchanged.
- Events during service: a second edge on the in-service source during SERVICE → pending re-set, no pulse until rsi, then pulse with the same id.
- Reset mid-service: assert rst_n low during SERVICE → busy=0, pending=0, mask=4'b1111 asynchronously. With IRQ_COUNT_EN, 3 takes of source 1 give irq_count=3.
